mem_stage_ctrl: RTL and testbench
=================================

# mem_stage_ctrl

Clocked memory-access controller between the pipeline MEM stage and the 256-byte big-endian data RAM (`dataRAM256x8`). It accepts one load/store request at a time, checks alignment and range, and drives the RAM's Enable/ReadWrite/Mode/Address/DataIn pins with clean one-cycle Enable pulses. Doublewords are split into two word accesses. Load data is captured, sign- or zero-extended, and returned with a one-cycle valid strobe.

## Interface
- `MEM_BYTES`, 256: RAM size in bytes. An access whose last byte is at or beyond this address is out of range.
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset. One clock; reset is synchronous and active-low.
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; a request is accepted on an edge where req_valid && req_ready
- req_rw  in  1  0 = load, 1 = store
- req_mode  in  2  00 byte, 01 halfword, 10 word, 11 doubleword
- req_signed  in  1  sign-extend byte/halfword loads
- req_addr  in  32  byte address
- req_wdata  in  64  store data; [63:32] goes to addr, [31:0] goes to addr+4 (dword only)
- resp_valid  out  1  one-cycle completion strobe
- resp_err  out  1  valid with resp_valid; misaligned or out-of-range access
- resp_rdata_hi  out  32  dword word at addr; 0 otherwise
- resp_rdata_lo  out  32  load result; for dword, the word at addr+4
- ram_enable  out  1  to RAM Enable
- ram_rw  out  1  to RAM ReadWrite
- ram_mode  out  2  to RAM Mode; never 11
- ram_addr  out  32  to RAM Address
- ram_wdata  out  32  to RAM DataIn
- ram_rdata  in  32  from RAM DataOut

## Operation
- States: IDLE, ACC0, GAP, ACC1, DONE.
- **Accept (IDLE):**
  - Latch rw, mode, signed, addr, and wdata.
  - Check alignment: half needs addr[0]=0, word needs addr[1:0]=0, dword needs addr[2:0]=0.
  - Check range: addr + size − 1 < MEM_BYTES.
  - Any violation: go to DONE with resp_err=1, no RAM access, and resp data 0.
  - Otherwise go to ACC0.
- **ACC0:**
  - ram_enable=1.
  - ram_addr = addr.
  - ram_mode = the request mode, except dword, which uses 10.
  - ram_wdata:
    - byte: {24'b0, wdata[7:0]}
    - half: {16'b0, wdata[15:0]}
    - word: wdata[31:0]
    - dword: wdata[63:32]
  - Next state: GAP if dword, else DONE.
  - For a load, capture ram_rdata on the exiting edge.
- **GAP:**
  - ram_enable=0, so the RAM sees a fresh rising edge at the next access.
  - Next state: ACC1.
- **ACC1:**
  - ram_enable=1.
  - ram_addr = addr+4, ram_mode=10, ram_wdata = wdata[31:0].
  - For a load, capture into lo.
  - Next state: DONE.
- **DONE:**
  - resp_valid=1 and ram_enable=0.
  - Next state: IDLE.
- **Load result:**
  - byte: signed gives {{24{d[7]}}, d[7:0]}; unsigned gives {24'b0, d[7:0]}.
  - half: same rule using bit 15.
  - word: passed unchanged.
  - dword: hi = first capture, lo = second capture.
- **Stores:** resp_rdata_* = 0.
- **Busy:** req_valid while not in IDLE is ignored; it is neither queued nor accepted.
- **Other outputs:** ram_rw, ram_addr, and ram_mode hold the latched values from ACC0 through DONE and are stable while ram_enable is high.

## Timing
- All outputs are registered except req_ready, which is decoded as state==IDLE.
- **Reset values:**
  - req_ready=1.
  - Low/zero: ram_enable, ram_rw, ram_mode, ram_addr, ram_wdata, resp_valid, resp_err, resp_rdata_hi, resp_rdata_lo.
- **Latency from accept edge to resp_valid:**
  - Byte, half, word, and error: 2 cycles.
  - Dword: 4 cycles.
- **Throughput:** one request per 3 cycles (single) or 5 cycles (dword). req_ready is low in ACC0, GAP, ACC1, and DONE.
- **Enable pulses:** each pulse is exactly one cycle wide. Two pulses are always separated by at least one low cycle.
- **Reset mid-operation (reset_n low at an edge):**
  - State goes to IDLE and ram_enable=0 on that edge.
  - No further RAM access is issued and no resp_valid is produced.
  - A dword store interrupted in GAP has written only its first word.
- **Simultaneous reset_n=0 and req_valid:** reset wins; nothing is accepted.

## Test plan
- Setup: RAM bytes 0–7 preloaded with 80 01 02 03 F0 05 06 07.
- Word load at addr 0 -> one ram_enable pulse with mode 10; resp_valid 2 cycles after accept with lo=0x80010203, err=0.
- Byte and half loads:
  - Signed byte at addr 0 -> 0xFFFFFF80.
  - Unsigned byte at addr 0 -> 0x00000080.
  - Signed half at addr 4 -> 0xFFFFF005.
  - Unsigned half at addr 4 -> 0x0000F005.
- Dword store then load at addr 8:
  - Store wdata 0x11223344_55667788 -> two pulses (addr 8 then 12, mode 10, rw=1) with one low cycle between them.
  - Dword load at addr 8 -> hi=0x11223344, lo=0x55667788, resp_valid 4 cycles after accept.
- Error requests:
  - Word at addr 2 -> err=1, no enable pulse, resp_valid after 2 cycles, data 0.
  - Half at addr 0xFF -> err=1.
  - Word at addr 0x100 -> err=1.
- Reset during GAP of a dword store of 0xAAAAAAAA_BBBBBBBB at addr 16:
  - Next edge: state IDLE, ram_enable=0, no resp_valid.
  - Mem[16..19]=AA, Mem[20..23] unchanged.
- req_valid held high for 10 cycles with word loads -> exactly one accept per 3 cycles; no accept while busy.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM-stage load/store controller for a 256-byte big-endian data RAM
module mem_stage_ctrl #(
  parameter int MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [1:0]  req_mode,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata_hi,
  output logic [31:0] resp_rdata_lo,
  output logic        ram_enable,
  output logic        ram_rw,
  output logic [1:0]  ram_mode,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [2:0] {IDLE, ACC0, GAP, ACC1, DONE} state_t;

  localparam logic [1:0] MODE_BYTE  = 2'b00;
  localparam logic [1:0] MODE_HALF  = 2'b01;
  localparam logic [1:0] MODE_WORD  = 2'b10;
  localparam logic [1:0] MODE_DWORD = 2'b11;

  state_t      state_q, state_d;
  logic        rw_q, rw_d;
  logic [1:0]  mode_q, mode_d;
  logic        sgn_q, sgn_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_lo_q, wdata_lo_d;
  logic        err_q, err_d;
  logic [31:0] hi_cap_q, hi_cap_d;
  logic        ram_enable_q, ram_enable_d;
  logic        ram_rw_q, ram_rw_d;
  logic [1:0]  ram_mode_q, ram_mode_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_hi_q, resp_hi_d;
  logic [31:0] resp_lo_q, resp_lo_d;

  logic        accept;
  logic        req_misaligned;
  logic        req_err;
  logic [32:0] req_last;

  assign req_ready     = (state_q == IDLE);
  assign accept        = req_valid && req_ready;
  assign ram_enable    = ram_enable_q;
  assign ram_rw        = ram_rw_q;
  assign ram_mode      = ram_mode_q;
  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;
  assign resp_valid    = resp_valid_q;
  assign resp_err      = resp_err_q;
  assign resp_rdata_hi = resp_hi_q;
  assign resp_rdata_lo = resp_lo_q;

  // Data lane presented to the RAM on the first access; dword sends its upper word first
  function automatic logic [31:0] store_lane(input logic [1:0] mode, input logic [63:0] wd);
    logic [31:0] r;
    case (mode)
      MODE_BYTE: r = {24'b0, wd[7:0]};
      MODE_HALF: r = {16'b0, wd[15:0]};
      MODE_WORD: r = wd[31:0];
      default:   r = wd[63:32];
    endcase
    return r;
  endfunction

  // Sign or zero extension of a narrow load; word data passes through
  function automatic logic [31:0] load_extend(input logic [1:0] mode, input logic sgn,
                                              input logic [31:0] d);
    logic [31:0] r;
    case (mode)
      MODE_BYTE: r = {{24{sgn & d[7]}}, d[7:0]};
      MODE_HALF: r = {{16{sgn & d[15]}}, d[15:0]};
      default:   r = d;
    endcase
    return r;
  endfunction

  // Alignment and range check on the incoming request; 33-bit sum so addresses near 2^32 cannot wrap
  always_comb begin
    req_misaligned = 1'b0;
    req_last       = {1'b0, req_addr};
    case (req_mode)
      MODE_BYTE: begin
        req_misaligned = 1'b0;
        req_last       = {1'b0, req_addr};
      end
      MODE_HALF: begin
        req_misaligned = req_addr[0];
        req_last       = {1'b0, req_addr} + 33'd1;
      end
      MODE_WORD: begin
        req_misaligned = |req_addr[1:0];
        req_last       = {1'b0, req_addr} + 33'd3;
      end
      default: begin
        req_misaligned = |req_addr[2:0];
        req_last       = {1'b0, req_addr} + 33'd7;
      end
    endcase
    req_err = req_misaligned || (req_last >= 33'(MEM_BYTES));
  end

  // State and registered-output flops
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rw_q         <= 1'b0;
      mode_q       <= 2'b00;
      sgn_q        <= 1'b0;
      addr_q       <= 32'b0;
      wdata_lo_q   <= 32'b0;
      err_q        <= 1'b0;
      hi_cap_q     <= 32'b0;
      ram_enable_q <= 1'b0;
      ram_rw_q     <= 1'b0;
      ram_mode_q   <= 2'b00;
      ram_addr_q   <= 32'b0;
      ram_wdata_q  <= 32'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_hi_q    <= 32'b0;
      resp_lo_q    <= 32'b0;
    end else begin
      state_q      <= state_d;
      rw_q         <= rw_d;
      mode_q       <= mode_d;
      sgn_q        <= sgn_d;
      addr_q       <= addr_d;
      wdata_lo_q   <= wdata_lo_d;
      err_q        <= err_d;
      hi_cap_q     <= hi_cap_d;
      ram_enable_q <= ram_enable_d;
      ram_rw_q     <= ram_rw_d;
      ram_mode_q   <= ram_mode_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_hi_q    <= resp_hi_d;
      resp_lo_q    <= resp_lo_d;
    end
  end

  // Next state; rejected requests still spend one ACC0 slot so every single access takes 3 cycles
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACC0;
      ACC0:    state_d = (!err_q && mode_q == MODE_DWORD) ? GAP : DONE;
      GAP:     state_d = ACC1;
      ACC1:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed for the state being entered so the RAM pins change exactly on state edges
  always_comb begin
    rw_d         = rw_q;
    mode_d       = mode_q;
    sgn_d        = sgn_q;
    addr_d       = addr_q;
    wdata_lo_d   = wdata_lo_q;
    err_d        = err_q;
    hi_cap_d     = hi_cap_q;
    ram_enable_d = 1'b0;
    ram_rw_d     = ram_rw_q;
    ram_mode_d   = ram_mode_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_hi_d    = 32'b0;
    resp_lo_d    = 32'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rw_d       = req_rw;
          mode_d     = req_mode;
          sgn_d      = req_signed;
          addr_d     = req_addr;
          wdata_lo_d = req_wdata[31:0];
          err_d      = req_err;
          if (!req_err) begin
            ram_enable_d = 1'b1;
            ram_rw_d     = req_rw;
            ram_mode_d   = (req_mode == MODE_DWORD) ? MODE_WORD : req_mode;
            ram_addr_d   = req_addr;
            ram_wdata_d  = store_lane(req_mode, req_wdata);
          end
        end
      end
      ACC0: begin
        if (state_d == GAP) begin
          hi_cap_d = ram_rdata;
        end else begin
          resp_valid_d = 1'b1;
          resp_err_d   = err_q;
          if (!err_q && !rw_q) resp_lo_d = load_extend(mode_q, sgn_q, ram_rdata);
        end
      end
      GAP: begin
        ram_enable_d = 1'b1;
        ram_addr_d   = addr_q + 32'd4;
        ram_mode_d   = MODE_WORD;
        ram_wdata_d  = wdata_lo_q;
      end
      ACC1: begin
        resp_valid_d = 1'b1;
        if (!rw_q) begin
          resp_hi_d = hi_cap_q;
          resp_lo_d = ram_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - table-driven bench for mem_stage_ctrl with a big-endian RAM model
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [1:0]  req_mode;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata_hi;
  logic [31:0] resp_rdata_lo;
  logic        ram_enable;
  logic        ram_rw;
  logic [1:0]  ram_mode;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int total = 0;
  int bad   = 0;

  mem_stage_ctrl #(.MEM_BYTES(256)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_mode(req_mode),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata_hi(resp_rdata_hi), .resp_rdata_lo(resp_rdata_lo),
    .ram_enable(ram_enable), .ram_rw(ram_rw), .ram_mode(ram_mode), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: combinational big-endian read, write once per enable pulse
  logic [7:0]  mem [256];
  logic [7:0]  ra;
  always_comb begin
    ra = ram_addr[7:0];
    case (ram_mode)
      2'b00:   ram_rdata = {24'b0, mem[ra]};
      2'b01:   ram_rdata = {16'b0, mem[ra], mem[ra + 8'd1]};
      default: ram_rdata = {mem[ra], mem[ra + 8'd1], mem[ra + 8'd2], mem[ra + 8'd3]};
    endcase
  end

  logic [31:0] pulse_addr [$];
  logic [1:0]  pulse_mode [$];
  logic        pulse_rw   [$];
  bit          prev_en;

  always @(negedge clk) begin
    if (ram_enable) begin
      total++;
      if (prev_en || ram_mode == 2'b11) begin
        bad++;
        $display("FAIL enable_pulse: prev_en=%0b mode=%0b want single-cycle pulse, mode!=11", prev_en, ram_mode);
      end
      if (!prev_en) begin
        pulse_addr.push_back(ram_addr);
        pulse_mode.push_back(ram_mode);
        pulse_rw.push_back(ram_rw);
      end
      if (ram_rw) begin
        case (ram_mode)
          2'b00: mem[ram_addr[7:0]] = ram_wdata[7:0];
          2'b01: begin
            mem[ram_addr[7:0]]         = ram_wdata[15:8];
            mem[ram_addr[7:0] + 8'd1]  = ram_wdata[7:0];
          end
          default: begin
            mem[ram_addr[7:0]]         = ram_wdata[31:24];
            mem[ram_addr[7:0] + 8'd1]  = ram_wdata[23:16];
            mem[ram_addr[7:0] + 8'd2]  = ram_wdata[15:8];
            mem[ram_addr[7:0] + 8'd3]  = ram_wdata[7:0];
          end
        endcase
      end
    end
    prev_en = ram_enable;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rw;
    logic [1:0]  mode;
    logic        sgn;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        err;
    logic [31:0] hi;
    logic [31:0] lo;
    int          pulses;
    int          lat;
  } vec_t;

  vec_t vecs [19];

  task automatic do_req(input int idx, input vec_t v);
    int cyc;
    int p0;
    logic [1:0] em;
    @(negedge clk);
    check($sformatf("v%0d_ready", idx), req_ready, 1);
    req_valid  = 1'b1;
    req_rw     = v.rw;
    req_mode   = v.mode;
    req_signed = v.sgn;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    p0 = pulse_addr.size();
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("v%0d_latency", idx), cyc, v.lat);
    check($sformatf("v%0d_err", idx), resp_err, v.err);
    check($sformatf("v%0d_hi", idx), resp_rdata_hi, v.hi);
    check($sformatf("v%0d_lo", idx), resp_rdata_lo, v.lo);
    check($sformatf("v%0d_pulses", idx), pulse_addr.size() - p0, v.pulses);
    em = (v.mode == 2'b11) ? 2'b10 : v.mode;
    if (v.pulses >= 1 && pulse_addr.size() > p0) begin
      check($sformatf("v%0d_addr0", idx), pulse_addr[p0], v.addr);
      check($sformatf("v%0d_mode0", idx), pulse_mode[p0], em);
      check($sformatf("v%0d_rw0", idx), pulse_rw[p0], v.rw);
    end
    if (v.pulses == 2 && pulse_addr.size() > p0 + 1) begin
      check($sformatf("v%0d_addr1", idx), pulse_addr[p0+1], v.addr + 32'd4);
      check($sformatf("v%0d_mode1", idx), pulse_mode[p0+1], 2'b10);
    end
    @(negedge clk);
    check($sformatf("v%0d_valid_drop", idx), resp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int nresp;
    int nacc;
    logic [9:0] pat;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h80; mem[1] = 8'h01; mem[2] = 8'h02; mem[3] = 8'h03;
    mem[4] = 8'hF0; mem[5] = 8'h05; mem[6] = 8'h06; mem[7] = 8'h07;
    mem[8'hF8] = 8'hCA; mem[8'hF9] = 8'hFE; mem[8'hFA] = 8'hBA; mem[8'hFB] = 8'hBE;
    mem[8'hFC] = 8'hDE; mem[8'hFD] = 8'hAD; mem[8'hFE] = 8'hBE; mem[8'hFF] = 8'hEF;

    //          rw    mode   sgn   addr       wdata                   err   hi            lo            p  lat
    vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h00,  64'h0,                  1'b0, 32'h0,        32'h80010203, 1, 2};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h00,  64'h0,                  1'b0, 32'h0,        32'hFFFFFF80, 1, 2};
    vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h00,  64'h0,                  1'b0, 32'h0,        32'h00000080, 1, 2};
    vecs[3]  = '{1'b0, 2'b01, 1'b1, 32'h04,  64'h0,                  1'b0, 32'h0,        32'hFFFFF005, 1, 2};
    vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h04,  64'h0,                  1'b0, 32'h0,        32'h0000F005, 1, 2};
    vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h06,  64'h0,                  1'b0, 32'h0,        32'h00000607, 1, 2};
    vecs[6]  = '{1'b1, 2'b11, 1'b0, 32'h08,  64'h11223344_55667788, 1'b0, 32'h0,        32'h0,        2, 4};
    vecs[7]  = '{1'b0, 2'b11, 1'b0, 32'h08,  64'h0,                  1'b0, 32'h11223344, 32'h55667788, 2, 4};
    vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h02,  64'h0,                  1'b1, 32'h0,        32'h0,        0, 2};
    vecs[9]  = '{1'b0, 2'b01, 1'b0, 32'hFF,  64'h0,                  1'b1, 32'h0,        32'h0,        0, 2};
    vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h100, 64'h0,                  1'b1, 32'h0,        32'h0,        0, 2};
    vecs[11] = '{1'b0, 2'b01, 1'b0, 32'h01,  64'h0,                  1'b1, 32'h0,        32'h0,        0, 2};
    vecs[12] = '{1'b0, 2'b11, 1'b0, 32'h04,  64'h0,                  1'b1, 32'h0,        32'h0,        0, 2};
    vecs[13] = '{1'b0, 2'b10, 1'b0, 32'hFC,  64'h0,                  1'b0, 32'h0,        32'hDEADBEEF, 1, 2};
    vecs[14] = '{1'b0, 2'b11, 1'b0, 32'hF8,  64'h0,                  1'b0, 32'hCAFEBABE, 32'hDEADBEEF, 2, 4};
    vecs[15] = '{1'b1, 2'b00, 1'b0, 32'h20,  64'h55555555_000012AB, 1'b0, 32'h0,        32'h0,        1, 2};
    vecs[16] = '{1'b0, 2'b00, 1'b1, 32'h20,  64'h0,                  1'b0, 32'h0,        32'hFFFFFFAB, 1, 2};
    vecs[17] = '{1'b1, 2'b01, 1'b0, 32'h22,  64'h0000FFFF_00009876, 1'b0, 32'h0,        32'h0,        1, 2};
    vecs[18] = '{1'b0, 2'b10, 1'b0, 32'h20,  64'h0,                  1'b0, 32'h0,        32'hAB009876, 1, 2};

    // reset held while a request is presented: reset wins
    reset_n    = 1'b0;
    req_valid  = 1'b1;
    req_rw     = 1'b0;
    req_mode   = 2'b10;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 64'h0;
    repeat (3) @(negedge clk);
    check("reset_ready", req_ready, 1);
    check("reset_ram", {ram_enable, ram_rw, ram_mode, ram_addr, ram_wdata}, 0);
    check("reset_resp", {resp_valid, resp_err, resp_rdata_hi}, 0);
    check("reset_resp_lo", resp_rdata_lo, 0);
    reset_n   = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {req_ready, ram_enable}, 2'b10);

    for (int i = 0; i < 19; i++) do_req(i, vecs[i]);

    // reset during GAP of a dword store
    @(negedge clk);
    req_valid = 1'b1;
    req_rw    = 1'b1;
    req_mode  = 2'b11;
    req_addr  = 32'd16;
    req_wdata = 64'hAAAAAAAA_BBBBBBBB;
    @(negedge clk);
    req_valid = 1'b0;
    check("gap_acc0_enable", ram_enable, 1);
    @(negedge clk);
    check("gap_state", {req_ready, ram_enable}, 2'b00);
    reset_n = 1'b0;
    @(negedge clk);
    check("gap_reset_state", {req_ready, ram_enable, resp_valid}, 3'b100);
    reset_n = 1'b1;
    p0 = pulse_addr.size();
    nresp = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) nresp++;
    end
    check("gap_no_resp", nresp, 0);
    check("gap_no_pulse", pulse_addr.size() - p0, 0);
    check("gap_first_word", {mem[16], mem[17], mem[18], mem[19]}, 32'hAAAAAAAA);
    check("gap_second_word", {mem[20], mem[21], mem[22], mem[23]}, 32'h00000000);

    // req_valid held high for 10 cycles of word loads
    @(negedge clk);
    req_valid = 1'b1;
    req_rw    = 1'b0;
    req_mode  = 2'b10;
    req_addr  = 32'h0;
    nresp = 0;
    nacc  = 0;
    for (int i = 0; i < 10; i++) begin
      pat[i] = req_ready;
      if (req_ready) nacc++;
      if (resp_valid) begin
        nresp++;
        check($sformatf("tp_lo%0d", i), resp_rdata_lo, 32'h80010203);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (4) begin
      if (resp_valid) nresp++;
      @(negedge clk);
    end
    check("tp_ready_pattern", pat, 10'b1001001001);
    check("tp_accepts", nacc, 4);
    check("tp_responses", nresp, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
